fu_issue_arbiter: RTL and testbench
===================================

Name: fu_issue_arbiter

Overview:
- Round-robin issue arbiter between the reservation-station entries and the shared execute path behind the ID/EX pipeline register.
- Each cycle, selects at most one ready requester and issues it to execute through a registered issue stage.
- Memory ops are throttled by a busy counter that models LSU occupancy.
- Supports downstream stall and pipeline flush.

Parameters:
- NUM_REQ, 4, number of requesters (reservation-station entries); must be ≥2.
- TAG_W, 6, width of the ROB tag carried with each request.
- MEM_BUSY_CYC, 3, cycles the LSU stays busy after a memory op is granted; must be ≥1.

Ports:
- clk  in  1  clock
- rstn  in  1  reset
- flush  in  1  pipeline flush (mispredict/exception); kills the current cycle's grant and the issue stage
- stall_in  in  1  execute stage cannot accept; hold the issue stage
- req_valid  in  NUM_REQ  per-requester ready-to-issue
- req_is_mem  in  NUM_REQ  per-requester op is load/store
- req_tag  in  NUM_REQ*TAG_W  packed ROB tags; requester i occupies bits [i*TAG_W +: TAG_W]
- grant  out  NUM_REQ  one-hot combinational grant, same cycle as the request
- issue_valid  out  1  registered: issue stage holds a valid op
- issue_tag  out  TAG_W  registered ROB tag of the issued op
- issue_is_mem  out  1  registered memory flag of the issued op
- issue_src  out  clog2(NUM_REQ)  registered index of the granted requester
- lsu_busy  out  1  registered: busy counter is nonzero

Behaviour:
- Clock and reset: clk, rstn; reset is asynchronous and active-low. All state updates on the rising clk edge.
- Reset values: issue_valid=0, issue_tag=0, issue_is_mem=0, issue_src=0, rr_ptr=0, busy_cnt=0, lsu_busy=0.
- grant is combinational; with no requests it is all zero.
- Requester contract: hold req_valid, req_is_mem and req_tag stable until granted. The arbiter keeps no per-requester state.
- Eligibility: elig[i] = req_valid[i] & ~(req_is_mem[i] & lsu_busy).
- Grant enable: gen = ~stall_in & ~flush. When gen=0, grant is all zero.
- Selection: the first eligible index searching upward from rr_ptr, wrapping modulo NUM_REQ. At most one grant bit is set.
- Round-robin pointer: on any grant to index i, rr_ptr <= (i+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0. With no grant, rr_ptr holds.
- Issue stage, priority order:
  - flush: issue_valid <= 0; other issue fields hold.
  - else stall_in: all issue_* fields hold.
  - else: issue_valid <= |grant. On a grant, issue_tag/is_mem/src <= the winner's values; with no grant these fields hold.
- Latency: a request granted in cycle t appears on issue_* in cycle t+1.
- Busy counter (width clog2(MEM_BUSY_CYC+1)):
  - A mem grant loads busy_cnt <= MEM_BUSY_CYC.
  - Otherwise, if busy_cnt != 0, decrement.
  - lsu_busy = (busy_cnt != 0), taken from the register.
- Mem issue spacing: with a mem grant in cycle t, lsu_busy is high for cycles t+1..t+MEM_BUSY_CYC. The next mem grant is possible no earlier than t+MEM_BUSY_CYC+1.
- The counter keeps decrementing during stall_in and flush: the LSU drains independently, and an in-flight mem op is never aborted.
- Non-mem requests are never blocked by lsu_busy. A busy LSU skips mem requesters, and round-robin continues to later ALU requesters.
- Simultaneous flush and stall_in: flush wins (issue_valid <= 0).
- Reset asserted mid-operation clears all state immediately, including the busy count. Outputs are valid at reset values while rstn is low.

Test Plan:
- Reset, then req_valid=4'b1111, all ALU, tags 10,11,12,13, no stall -> grants 0,1,2,3,0 on consecutive cycles; issue_tag on the following cycles is 10,11,12,13,10; issue_valid stays 1.
- rr_ptr=3 (after a grant to 2), req_valid=4'b0011 -> grant=4'b0001, issue_src=0 next cycle, then grant=4'b0010.
- Requester 1 mem (tag 5), requester 2 mem (tag 6), MEM_BUSY_CYC=3, grant to 1 at cycle t -> lsu_busy high t+1..t+3; requester 2 granted at t+4; an ALU requester 3 is granted at t+1 despite lsu_busy.
- Issue holds tag 7; stall_in=1 for 2 cycles with requests pending -> grant=0, issue_tag/issue_valid frozen, busy_cnt still decrements; after release, arbitration resumes from the saved rr_ptr.
- flush=1 with req_valid=4'b0100 and issue_valid=1 -> grant=0 that cycle, issue_valid=0 next cycle, rr_ptr unchanged; flush and stall_in both high -> issue_valid=0.
- rstn pulsed low asynchronously while busy_cnt=2 and issue_valid=1 -> busy_cnt=0, lsu_busy=0, issue_valid=0 and rr_ptr=0 without a clock edge.

Source files
------------

// File: rtl/fu_issue_arbiter.sv
// fu_issue_arbiter: round-robin issue arbiter feeding the shared execute path.
//
// Each cycle picks at most one eligible requester, searching upward from a
// round-robin pointer, and registers it into a single issue stage. A busy
// counter models LSU occupancy and hides memory requesters while it runs.
//
// Ports:
//   clk, rstn     clock, asynchronous active-low reset
//   flush         kill this cycle's grant and invalidate the issue stage
//   stall_in      execute cannot accept: no grant, issue stage holds
//   req_valid     per-requester ready-to-issue
//   req_is_mem    per-requester load/store flag
//   req_tag       packed ROB tags, requester i at [i*TAG_W +: TAG_W]
//   grant         combinational one-hot grant
//   issue_valid   issue stage holds a valid op
//   issue_tag     ROB tag of the issued op
//   issue_is_mem  memory flag of the issued op
//   issue_src     index of the requester that was issued
//   lsu_busy      LSU busy counter is nonzero
module fu_issue_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned TAG_W        = 6,
  parameter int unsigned MEM_BUSY_CYC = 3
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  input  logic                       stall_in,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_is_mem,
  input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       issue_valid,
  output logic [TAG_W-1:0]           issue_tag,
  output logic                       issue_is_mem,
  output logic [$clog2(NUM_REQ)-1:0] issue_src,
  output logic                       lsu_busy
);

  localparam int unsigned SrcW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(MEM_BUSY_CYC + 1);
  localparam logic [CntW-1:0] BusyLoad = CntW'(MEM_BUSY_CYC);
  localparam logic [SrcW-1:0] LastIdx  = SrcW'(NUM_REQ - 1);

  logic [SrcW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]    busy_q, busy_d;
  logic               issue_valid_q, issue_valid_d;
  logic [TAG_W-1:0]   issue_tag_q, issue_tag_d;
  logic               issue_is_mem_q, issue_is_mem_d;
  logic [SrcW-1:0]    issue_src_q, issue_src_d;

  logic [NUM_REQ-1:0] elig;
  logic               gen;
  logic               win_found;
  logic [SrcW-1:0]    win_idx;
  logic [SrcW-1:0]    idx_v;
  logic [TAG_W-1:0]   win_tag;
  logic               win_mem;

  assign lsu_busy = (busy_q != '0);
  assign gen      = ~stall_in & ~flush;
  // A busy LSU only hides memory requesters; ALU requesters stay eligible.
  assign elig     = req_valid & ~(req_is_mem & {NUM_REQ{lsu_busy}});

  // First eligible index at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx_v     = '0;
    if (gen) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx_v = SrcW'((int'(rr_ptr_q) + k) % NUM_REQ);
        if (!win_found && elig[idx_v]) begin
          win_found = 1'b1;
          win_idx   = idx_v;
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    if (win_found) grant[win_idx] = 1'b1;
  end

  assign win_tag = req_tag[win_idx*TAG_W +: TAG_W];
  assign win_mem = req_is_mem[win_idx];

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (win_found) rr_ptr_d = (win_idx == LastIdx) ? '0 : win_idx + SrcW'(1);
  end

  // The LSU drains regardless of stall/flush.
  always_comb begin
    busy_d = busy_q;
    if (win_found && win_mem) busy_d = BusyLoad;
    else if (busy_q != '0)    busy_d = busy_q - CntW'(1);
  end

  always_comb begin
    issue_valid_d  = issue_valid_q;
    issue_tag_d    = issue_tag_q;
    issue_is_mem_d = issue_is_mem_q;
    issue_src_d    = issue_src_q;
    if (flush) begin
      issue_valid_d = 1'b0;
    end else if (!stall_in) begin
      issue_valid_d = win_found;
      if (win_found) begin
        issue_tag_d    = win_tag;
        issue_is_mem_d = win_mem;
        issue_src_d    = win_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_q       <= '0;
      busy_q         <= '0;
      issue_valid_q  <= 1'b0;
      issue_tag_q    <= '0;
      issue_is_mem_q <= 1'b0;
      issue_src_q    <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      busy_q         <= busy_d;
      issue_valid_q  <= issue_valid_d;
      issue_tag_q    <= issue_tag_d;
      issue_is_mem_q <= issue_is_mem_d;
      issue_src_q    <= issue_src_d;
    end
  end

  assign issue_valid  = issue_valid_q;
  assign issue_tag    = issue_tag_q;
  assign issue_is_mem = issue_is_mem_q;
  assign issue_src    = issue_src_q;

endmodule

// File: tb/tb_fu_issue_arbiter.sv
// Bench for fu_issue_arbiter: directed scenarios with literal expectations plus
// constrained-random traffic, all compared every cycle against a behavioural model.
module tb_fu_issue_arbiter;

  localparam int N  = 4;
  localparam int TW = 6;
  localparam int MB = 3;

  logic              clk = 1'b0;
  logic              rstn;
  logic              flush;
  logic              stall_in;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_is_mem;
  logic [N*TW-1:0]   req_tag;
  logic [N-1:0]      grant;
  logic              issue_valid;
  logic [TW-1:0]     issue_tag;
  logic              issue_is_mem;
  logic [1:0]        issue_src;
  logic              lsu_busy;

  fu_issue_arbiter #(
    .NUM_REQ      (N),
    .TAG_W        (TW),
    .MEM_BUSY_CYC (MB)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .flush        (flush),
    .stall_in     (stall_in),
    .req_valid    (req_valid),
    .req_is_mem   (req_is_mem),
    .req_tag      (req_tag),
    .grant        (grant),
    .issue_valid  (issue_valid),
    .issue_tag    (issue_tag),
    .issue_is_mem (issue_is_mem),
    .issue_src    (issue_src),
    .lsu_busy     (lsu_busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: pointer, cycles of LSU occupancy left, issue slot contents.
  int m_ptr, m_busy, m_tag, m_src, m_win;
  bit m_iv, m_mem;

  logic [N-1:0] g_obs;
  logic         lb_obs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_busy = 0; m_tag = 0; m_src = 0; m_iv = 0; m_mem = 0; m_win = -1;
  endtask

  function automatic int pick();
    int idx;
    if (stall_in || flush) return -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (req_valid[idx] && !(req_is_mem[idx] && m_busy > 0)) return idx;
    end
    return -1;
  endfunction

  task automatic model_step();
    if (m_win >= 0 && req_is_mem[m_win]) m_busy = MB;
    else if (m_busy > 0)                 m_busy = m_busy - 1;
    if (flush) begin
      m_iv = 0;
    end else if (!stall_in) begin
      m_iv = (m_win >= 0);
      if (m_win >= 0) begin
        m_tag = int'(req_tag[m_win*TW +: TW]);
        m_mem = req_is_mem[m_win];
        m_src = m_win;
      end
    end
    if (m_win >= 0) m_ptr = (m_win + 1) % N;
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle();
    #1;
    m_win  = pick();
    g_obs  = grant;
    lb_obs = lsu_busy;
    check("grant", 32'(grant), (m_win >= 0) ? (32'd1 << m_win) : 32'd0);
    check("issue_valid", 32'(issue_valid), 32'(m_iv));
    check("issue_tag", 32'(issue_tag), 32'(m_tag));
    check("issue_is_mem", 32'(issue_is_mem), 32'(m_mem));
    check("issue_src", 32'(issue_src), 32'(m_src));
    check("lsu_busy", 32'(lsu_busy), 32'(m_busy > 0));
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_tag(input int i, input int t);
    req_tag[i*TW +: TW] = TW'(t);
  endtask

  bit [N-1:0] pend;

  initial begin
    rstn = 1'b0; flush = 1'b0; stall_in = 1'b0;
    req_valid = '0; req_is_mem = '0; req_tag = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_issue_valid", 32'(issue_valid), 32'd0);
    check("rst_issue_tag", 32'(issue_tag), 32'd0);
    check("rst_lsu_busy", 32'(lsu_busy), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    rstn = 1'b1;

    // Full round robin over four ALU requesters.
    for (int i = 0; i < N; i++) set_tag(i, 10 + i);
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("rr_grant_lit", 32'(g_obs), 32'd1 << (i % 4));
      check("rr_tag_lit", 32'(issue_tag), 32'(10 + (i % 4)));
      check("rr_valid_lit", 32'(issue_valid), 32'd1);
    end

    // Wrap: grant to 2 leaves pointer at 3; then 0 wins before 1.
    req_valid = 4'b0100;
    cycle();
    check("wrap_g2_lit", 32'(g_obs), 32'b0100);
    req_valid = 4'b0011;
    cycle();
    check("wrap_g0_lit", 32'(g_obs), 32'b0001);
    check("wrap_src_lit", 32'(issue_src), 32'd0);
    req_valid = 4'b0010;
    cycle();
    check("wrap_g1_lit", 32'(g_obs), 32'b0010);

    // Mem throttling; pointer moved to 1 first.
    req_valid = 4'b0001;
    cycle();
    req_is_mem = 4'b0110;
    set_tag(1, 5); set_tag(2, 6); set_tag(3, 7);
    req_valid = 4'b1110;
    cycle();
    check("mem_t_lit", 32'(g_obs), 32'b0010);
    req_valid = 4'b1100;
    cycle();
    check("mem_t1_alu_lit", 32'(g_obs), 32'b1000);
    check("mem_t1_busy_lit", 32'(lb_obs), 32'd1);
    req_valid = 4'b0100;
    cycle();
    check("mem_t2_lit", 32'(g_obs), 32'd0);
    check("mem_t2_busy_lit", 32'(lb_obs), 32'd1);
    cycle();
    check("mem_t3_lit", 32'(g_obs), 32'd0);
    check("mem_t3_busy_lit", 32'(lb_obs), 32'd1);
    cycle();
    check("mem_t4_lit", 32'(g_obs), 32'b0100);
    check("mem_t4_busy_lit", 32'(lb_obs), 32'd0);

    // Stall holds the issue stage while the LSU keeps draining.
    req_is_mem = '0;
    set_tag(0, 7);
    req_valid = 4'b0001;
    cycle();
    check("stall_pre_lit", 32'(issue_tag), 32'd7);
    req_valid = 4'b0110;
    stall_in  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      check("stall_g_lit", 32'(g_obs), 32'd0);
      check("stall_tag_lit", 32'(issue_tag), 32'd7);
      check("stall_v_lit", 32'(issue_valid), 32'd1);
    end
    stall_in = 1'b0;
    cycle();
    check("stall_resume_lit", 32'(g_obs), 32'b0010);

    // Flush kills the grant and the issue stage, pointer untouched.
    req_valid = 4'b0100;
    flush = 1'b1;
    cycle();
    check("flush_g_lit", 32'(g_obs), 32'd0);
    check("flush_v_lit", 32'(issue_valid), 32'd0);
    flush = 1'b0;
    cycle();
    check("flush_after_lit", 32'(g_obs), 32'b0100);
    req_valid = '0;
    flush = 1'b1; stall_in = 1'b1;
    cycle();
    check("flush_stall_v_lit", 32'(issue_valid), 32'd0);
    flush = 1'b0; stall_in = 1'b0;

    // Asynchronous reset with busy count 2 and a valid issue.
    repeat (4) cycle();
    req_is_mem = 4'b0001; set_tag(0, 9);
    req_valid = 4'b0001;
    cycle();
    req_is_mem = '0;
    req_valid = 4'b0010;
    cycle();
    req_valid = '0;
    check("prerst_v_lit", 32'(issue_valid), 32'd1);
    check("prerst_busy_lit", 32'(lsu_busy), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("arst_v_lit", 32'(issue_valid), 32'd0);
    check("arst_busy_lit", 32'(lsu_busy), 32'd0);
    check("arst_tag_lit", 32'(issue_tag), 32'd0);
    check("arst_src_lit", 32'(issue_src), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    req_valid = 4'b1111;
    cycle();
    check("arst_ptr_lit", 32'(g_obs), 32'b0001);

    // Random traffic honouring the hold-until-granted contract.
    pend = '0;
    req_valid = '0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]       = 1'b1;
          req_is_mem[i] = 1'($urandom_range(0, 1));
          set_tag(i, int'($urandom_range(0, 63)));
        end
      end
      req_valid = pend;
      stall_in  = ($urandom_range(0, 6) == 0);
      flush     = ($urandom_range(0, 11) == 0);
      cycle();
      if (m_win >= 0) pend[m_win] = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
